// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key event sequencer.
//   - Scan-code prefix and error byte constants.
//   - key_event_t: one queued event {ext, brk, code}.
//   - seq_state_t: prefix-tracking FSM states.
package ps2_pkg;

   localparam logic [7:0] KEYUP  = 8'hF0;
   localparam logic [7:0] EXTEND = 8'hE0;
   localparam logic [7:0] PAUSE  = 8'hE1;
   localparam logic [7:0] ERR_LO = 8'h00;
   localparam logic [7:0] ERR_HI = 8'hFF;

   localparam int KEY_EVENT_W = 10;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_event_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GOT_E0   = 2'd1,
      GOT_F0   = 2'd2,
      GOT_E0F0 = 2'd3
   } seq_state_t;

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through FIFO of key events.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   push_i         write push_data_i (taken only when not full, or when popping)
//   push_data_i    packed key_event_t
//   pop_i          remove head (ignored when empty)
//   head_o         current head; all zeros when empty
//   full_o/empty_o occupancy flags
module key_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [KEY_EVENT_W-1:0] push_data_i,
   input  logic                   pop_i,
   output logic [KEY_EVENT_W-1:0] head_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   key_event_t  mem_q [DEPTH];
   key_event_t  mem_d [DEPTH];
   logic        wr_en;
   logic        rd_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);

   // A push into a full FIFO fits only because the head slot is freed this cycle.
   assign wr_en = push_i && (!full_o || pop_i);
   assign rd_en = pop_i && !empty_o;

   assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q[AW-1:0]] = key_event_t'(push_data_i);
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage is not reset; head_o is masked while empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/ps2_key_event_sequencer.sv
// Turns raw PS/2 scan-code bytes into make/break key events.
// Tracks E0/F0 prefixes, abandons a stalled prefix after TIMEOUT_CYCLES idle
// cycles, suppresses typematic repeats of the held key, and queues events in
// a FWFT FIFO read with a valid/ready handshake.
// Ports:
//   Clock, Reset              clock, synchronous active-high reset
//   CodeValid, KeyboardCode   one-cycle strobe with a received byte
//   EvtValid, EvtReady        output handshake for the FIFO head
//   EvtCode/EvtBreak/EvtExtended  head event fields (0 when empty)
//   KeyHeld, HeldCode, HeldExt    currently pressed key (zeros when none)
//   Overflow                  sticky: an event was dropped on a full FIFO
module ps2_key_event_sequencer
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       CodeValid,
   input  logic [7:0] KeyboardCode,
   output logic       EvtValid,
   input  logic       EvtReady,
   output logic [7:0] EvtCode,
   output logic       EvtBreak,
   output logic       EvtExtended,
   output logic       KeyHeld,
   output logic [7:0] HeldCode,
   output logic       HeldExt,
   output logic       Overflow
);

   localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             held_q, held_d;
   logic [7:0]       held_code_q, held_code_d;
   logic             held_ext_q, held_ext_d;
   logic             overflow_q, overflow_d;

   logic             evt_gen;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic             is_err;
   logic             held_match;
   key_event_t       evt;
   key_event_t       head;
   logic [KEY_EVENT_W-1:0] head_raw;

   assign is_err = (KeyboardCode == ERR_LO) || (KeyboardCode == ERR_HI) ||
                   (KeyboardCode == PAUSE);

   // Prefix FSM and timeout counter.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      evt_gen  = 1'b0;
      evt.ext  = 1'b0;
      evt.brk  = 1'b0;
      evt.code = KeyboardCode;
      if (CodeValid) begin
         cnt_d = '0;
         unique case (state_q)
            IDLE: begin
               if (KeyboardCode == EXTEND)     state_d = GOT_E0;
               else if (KeyboardCode == KEYUP) state_d = GOT_F0;
               else if (!is_err)               evt_gen = 1'b1;
            end
            GOT_E0: begin
               if (KeyboardCode == KEYUP) begin
                  state_d = GOT_E0F0;
               end else if (KeyboardCode != EXTEND) begin
                  state_d = IDLE;
                  evt_gen = !is_err;
                  evt.ext = 1'b1;
               end
            end
            GOT_F0, GOT_E0F0: begin
               if (KeyboardCode != KEYUP) begin
                  state_d = IDLE;
                  evt_gen = !is_err && (KeyboardCode != EXTEND);
                  evt.brk = 1'b1;
                  evt.ext = (state_q == GOT_E0F0);
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (cnt_q == CNT_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Held-key tracking; a make of the already-held key is a typematic repeat.
   assign held_match = held_q && (held_code_q == evt.code) && (held_ext_q == evt.ext);

   always_comb begin
      held_d      = held_q;
      held_code_d = held_code_q;
      held_ext_d  = held_ext_q;
      push        = 1'b0;
      if (evt_gen) begin
         if (!evt.brk) begin
            if (!held_match) begin
               push        = 1'b1;
               held_d      = 1'b1;
               held_code_d = evt.code;
               held_ext_d  = evt.ext;
            end
         end else begin
            push = 1'b1;
            if (held_match) begin
               held_d      = 1'b0;
               held_code_d = 8'h00;
               held_ext_d  = 1'b0;
            end
         end
      end
   end

   assign pop        = EvtValid && EvtReady;
   assign overflow_d = overflow_q || (push && full && !pop);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         held_q      <= 1'b0;
         held_code_q <= 8'h00;
         held_ext_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         held_q      <= held_d;
         held_code_q <= held_code_d;
         held_ext_q  <= held_ext_d;
         overflow_q  <= overflow_d;
      end
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (Clock),
      .rst         (Reset),
      .push_i      (push),
      .push_data_i (evt),
      .pop_i       (pop),
      .head_o      (head_raw),
      .full_o      (full),
      .empty_o     (empty)
   );

   assign head        = key_event_t'(head_raw);
   assign EvtValid    = !empty;
   assign EvtCode     = head.code;
   assign EvtBreak    = head.brk;
   assign EvtExtended = head.ext;
   assign KeyHeld     = held_q;
   assign HeldCode    = held_code_q;
   assign HeldExt     = held_ext_q;
   assign Overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
module tb_ps2_key_event_sequencer;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       CodeValid;
   logic [7:0] KeyboardCode;
   logic       EvtValid;
   logic       EvtReady;
   logic [7:0] EvtCode;
   logic       EvtBreak;
   logic       EvtExtended;
   logic       KeyHeld;
   logic [7:0] HeldCode;
   logic       HeldExt;
   logic       Overflow;

   int checks = 0;
   int errors = 0;

   ps2_key_event_sequencer #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .CodeValid    (CodeValid),
      .KeyboardCode (KeyboardCode),
      .EvtValid     (EvtValid),
      .EvtReady     (EvtReady),
      .EvtCode      (EvtCode),
      .EvtBreak     (EvtBreak),
      .EvtExtended  (EvtExtended),
      .KeyHeld      (KeyHeld),
      .HeldCode     (HeldCode),
      .HeldExt      (HeldExt),
      .Overflow     (Overflow)
   );

   always #5 Clock = ~Clock;

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      CodeValid    = 1'b1;
      KeyboardCode = b;
      @(posedge Clock); #1;
      CodeValid    = 1'b0;
   endtask

   task automatic pop_one();
      EvtReady = 1'b1;
      @(posedge Clock); #1;
      EvtReady = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
   endtask

   // {EvtValid, EvtBreak, EvtExtended, EvtCode}
   function automatic logic [10:0] head_vec();
      return {EvtValid, EvtBreak, EvtExtended, EvtCode};
   endfunction

   task automatic test_reset();
      logic [20:0] outs;
      do_reset();
      outs = {EvtValid, EvtCode, EvtBreak, EvtExtended, KeyHeld, HeldCode, HeldExt, Overflow};
      checks++;
      if (outs !== 21'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", outs);
      end
   endtask

   task automatic test_make_break();
      do_reset();
      send_byte(8'h1C);
      checks++;
      if (head_vec() !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
         errors++; $display("FAIL t1_make_head got %h want %h", head_vec(), {1'b1, 1'b0, 1'b0, 8'h1C});
      end
      checks++;
      if ({KeyHeld, HeldExt, HeldCode} !== {1'b1, 1'b0, 8'h1C}) begin
         errors++; $display("FAIL t1_held got %h want %h", {KeyHeld, HeldExt, HeldCode}, {1'b1, 1'b0, 8'h1C});
      end
      send_byte(8'hF0);
      send_byte(8'h1C);
      checks++;
      if ({KeyHeld, HeldExt, HeldCode} !== 10'h0) begin
         errors++; $display("FAIL t1_released got %h want 0", {KeyHeld, HeldExt, HeldCode});
      end
      checks++;
      if (head_vec() !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
         errors++; $display("FAIL t1_head_kept got %h want %h", head_vec(), {1'b1, 1'b0, 1'b0, 8'h1C});
      end
      pop_one();
      checks++;
      if (head_vec() !== {1'b1, 1'b1, 1'b0, 8'h1C}) begin
         errors++; $display("FAIL t1_break_head got %h want %h", head_vec(), {1'b1, 1'b1, 1'b0, 8'h1C});
      end
      pop_one();
      checks++;
      if (EvtValid !== 1'b0) begin
         errors++; $display("FAIL t1_drained got %b want 0", EvtValid);
      end
   endtask

   task automatic test_extended();
      do_reset();
      send_byte(8'hE0);
      send_byte(8'h75);
      checks++;
      if (head_vec() !== {1'b1, 1'b0, 1'b1, 8'h75}) begin
         errors++; $display("FAIL t2_make_head got %h want %h", head_vec(), {1'b1, 1'b0, 1'b1, 8'h75});
      end
      checks++;
      if ({KeyHeld, HeldExt, HeldCode} !== {1'b1, 1'b1, 8'h75}) begin
         errors++; $display("FAIL t2_held got %h want %h", {KeyHeld, HeldExt, HeldCode}, {1'b1, 1'b1, 8'h75});
      end
      pop_one();
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      checks++;
      if (head_vec() !== {1'b1, 1'b1, 1'b1, 8'h75}) begin
         errors++; $display("FAIL t2_break_head got %h want %h", head_vec(), {1'b1, 1'b1, 1'b1, 8'h75});
      end
      checks++;
      if ({KeyHeld, HeldExt, HeldCode} !== 10'h0) begin
         errors++; $display("FAIL t2_released got %h want 0", {KeyHeld, HeldExt, HeldCode});
      end
   endtask

   task automatic test_typematic();
      logic [10:0] got [8];
      int          n;
      do_reset();
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h1C);
      n = 0;
      for (int i = 0; i < 8 && EvtValid; i++) begin
         got[n] = head_vec();
         n++;
         pop_one();
      end
      checks++;
      if (n !== 2) begin
         errors++; $display("FAIL t3_event_count got %0d want 2", n);
      end else begin
         checks++;
         if (got[0] !== {1'b1, 1'b0, 1'b0, 8'h1C} || got[1] !== {1'b1, 1'b1, 1'b0, 8'h1C}) begin
            errors++; $display("FAIL t3_events got %h,%h want %h,%h", got[0], got[1],
                               {1'b1, 1'b0, 1'b0, 8'h1C}, {1'b1, 1'b1, 1'b0, 8'h1C});
         end
      end
      send_byte(8'h1C);
      n = 0;
      for (int i = 0; i < 8 && EvtValid; i++) begin
         got[n] = head_vec();
         n++;
         pop_one();
      end
      checks++;
      if (n !== 1 || got[0] !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
         errors++; $display("FAIL t3_new_press got n=%0d head=%h want n=1 head=%h", n, got[0], {1'b1, 1'b0, 1'b0, 8'h1C});
      end
   endtask

   task automatic test_overflow();
      logic [7:0] codes [5];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
      do_reset();
      EvtReady = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(codes[i]);
      checks++;
      if (Overflow !== 1'b1) begin
         errors++; $display("FAIL t4_overflow got %b want 1", Overflow);
      end
      checks++;
      if ({KeyHeld, HeldCode} !== {1'b1, 8'h2C}) begin
         errors++; $display("FAIL t4_held got %h want %h", {KeyHeld, HeldCode}, {1'b1, 8'h2C});
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (head_vec() !== {1'b1, 1'b0, 1'b0, codes[i]}) begin
            errors++; $display("FAIL t4_order_%0d got %h want %h", i, head_vec(), {1'b1, 1'b0, 1'b0, codes[i]});
         end
         pop_one();
      end
      checks++;
      if ({EvtValid, Overflow} !== 2'b01) begin
         errors++; $display("FAIL t4_after_drain got %b want 01", {EvtValid, Overflow});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] codes [5];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(codes[i]);
      // Push into the full FIFO on the same edge as a pop.
      CodeValid    = 1'b1;
      KeyboardCode = codes[4];
      EvtReady     = 1'b1;
      @(posedge Clock); #1;
      CodeValid    = 1'b0;
      EvtReady     = 1'b0;
      checks++;
      if (Overflow !== 1'b0) begin
         errors++; $display("FAIL t5_overflow got %b want 0", Overflow);
      end
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (head_vec() !== {1'b1, 1'b0, 1'b0, codes[i]}) begin
            errors++; $display("FAIL t5_order_%0d got %h want %h", i, head_vec(), {1'b1, 1'b0, 1'b0, codes[i]});
         end
         pop_one();
      end
      checks++;
      if (EvtValid !== 1'b0) begin
         errors++; $display("FAIL t5_drained got %b want 0", EvtValid);
      end
   endtask

   task automatic test_timeout();
      // Prefix still live after a short gap.
      do_reset();
      send_byte(8'hF0);
      idle(5);
      send_byte(8'h1C);
      checks++;
      if (head_vec() !== {1'b1, 1'b1, 1'b0, 8'h1C}) begin
         errors++; $display("FAIL t6_short_gap got %h want %h", head_vec(), {1'b1, 1'b1, 1'b0, 8'h1C});
      end
      // Prefix abandoned after a long gap.
      do_reset();
      send_byte(8'hF0);
      idle(20);
      send_byte(8'h1C);
      checks++;
      if (head_vec() !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
         errors++; $display("FAIL t6_timeout got %h want %h", head_vec(), {1'b1, 1'b0, 1'b0, 8'h1C});
      end
      checks++;
      if (KeyHeld !== 1'b1) begin
         errors++; $display("FAIL t6_held got %b want 1", KeyHeld);
      end
   endtask

   task automatic test_error_bytes();
      do_reset();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'hE1);
      checks++;
      if (EvtValid !== 1'b0) begin
         errors++; $display("FAIL err_dropped got %b want 0", EvtValid);
      end
      send_byte(8'hE0);
      send_byte(8'h00);
      send_byte(8'h1C);
      checks++;
      if (head_vec() !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
         errors++; $display("FAIL err_prefix_cleared got %h want %h", head_vec(), {1'b1, 1'b0, 1'b0, 8'h1C});
      end
   endtask

   task automatic test_mid_reset();
      logic [20:0] outs;
      do_reset();
      send_byte(8'h1C);
      send_byte(8'hE0);
      do_reset();
      outs = {EvtValid, EvtCode, EvtBreak, EvtExtended, KeyHeld, HeldCode, HeldExt, Overflow};
      checks++;
      if (outs !== 21'h0) begin
         errors++; $display("FAIL mid_reset_outputs got %h want 0", outs);
      end
      send_byte(8'h75);
      checks++;
      if (head_vec() !== {1'b1, 1'b0, 1'b0, 8'h75}) begin
         errors++; $display("FAIL mid_reset_prefix got %h want %h", head_vec(), {1'b1, 1'b0, 1'b0, 8'h75});
      end
   endtask

   initial begin
      Reset        = 1'b1;
      CodeValid    = 1'b0;
      KeyboardCode = 8'h00;
      EvtReady     = 1'b0;
      @(posedge Clock); #1;
      test_reset();
      test_make_break();
      test_extended();
      test_typematic();
      test_overflow();
      test_back_to_back();
      test_timeout();
      test_error_bytes();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
